tap_dr_chain: RTL and testbench

JTAG instruction/data register datapath that sits directly downstream of the TAP controller FSM. It consumes the controller's 4-bit state code and the serial TDI line, and holds the instruction register plus three data registers: BYPASS, IDCODE and an 8-bit USER register. It drives TDO_Pad, which completes the scan path that the TAP controller alone does not produce. It is clocked on the same GCLK_Pad as the controller.

---
 rtl/tap_dr_chain.sv | 130 +++++++++++++
 tb/tb_tap_dr_chain.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_dr_chain.sv
// tap_dr_chain: JTAG IR plus BYPASS/IDCODE/USER data registers, driven by the TAP state code.
// Define TAP_DR_IDCODE_EN to build the IDCODE register; otherwise instruction 4'h1 decodes as BYPASS.
module tap_dr_chain #(
    parameter logic [31:0]       IDCODE_VAL = 32'h1000_0001,
    parameter int unsigned       USER_W     = 8,
    parameter logic [USER_W-1:0] USER_RST   = '0
) (
    input  logic              GCLK_Pad,
    input  logic              RST_Pad,
    input  logic [3:0]        tap_state,
    input  logic              TDI_Pad,
    output logic              TDO_Pad,
    output logic              tdo_oe,
    output logic [3:0]        ir_q,
    output logic [USER_W-1:0] user_q
);

    typedef enum logic [3:0] {
        ST_EX2DR   = 4'h0, ST_EX1DR = 4'h1, ST_SHDR  = 4'h2, ST_PAUSEDR = 4'h3,
        ST_SELIR   = 4'h4, ST_UPDDR = 4'h5, ST_CAPDR = 4'h6, ST_SELDR   = 4'h7,
        ST_EX2IR   = 4'h8, ST_EX1IR = 4'h9, ST_SHIR  = 4'hA, ST_PAUSEIR = 4'hB,
        ST_RTI     = 4'hC, ST_UPDIR = 4'hD, ST_CAPIR = 4'hE, ST_TLR     = 4'hF
    } tap_state_e;

    typedef enum logic [3:0] {
        INS_IDCODE = 4'h1,
        INS_USER   = 4'h2,
        INS_BYPASS = 4'hF
    } ins_e;

`ifdef TAP_DR_IDCODE_EN
    localparam logic [3:0] IR_RST = INS_IDCODE;
`else
    localparam logic [3:0] IR_RST = INS_BYPASS;
`endif

    tap_state_e        st;
    logic [3:0]        ir_sr;
    logic              bypass_q;
    logic [USER_W-1:0] user_sr;
    logic              sel_user;
    logic              sel_idcode;
    logic              idcode_tdo;

    assign st       = tap_state_e'(tap_state);
    assign sel_user = (ir_q == INS_USER);

`ifdef TAP_DR_IDCODE_EN
    logic [31:0] idcode_sr;

    assign sel_idcode = (ir_q == INS_IDCODE);
    assign idcode_tdo = idcode_sr[0];

    always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
        if (RST_Pad) begin
            idcode_sr <= IDCODE_VAL;
        end else if (sel_idcode) begin
            if (st == ST_CAPDR)
                idcode_sr <= IDCODE_VAL;
            else if (st == ST_SHDR)
                idcode_sr <= {TDI_Pad, idcode_sr[31:1]};
        end
    end
`else
    logic unused_idcode_val;

    assign sel_idcode        = 1'b0;
    assign idcode_tdo        = 1'b0;
    assign unused_idcode_val = ^IDCODE_VAL;
`endif

    always_ff @(posedge GCLK_Pad or posedge RST_Pad) begin
        if (RST_Pad) begin
            ir_q     <= IR_RST;
            ir_sr    <= 4'b0101;
            bypass_q <= 1'b0;
            user_sr  <= '0;
            user_q   <= USER_RST;
        end else begin
            case (st)
                ST_TLR:   ir_q  <= IR_RST;
                ST_CAPIR: ir_sr <= 4'b0101;
                ST_SHIR:  ir_sr <= {TDI_Pad, ir_sr[3:1]};
                ST_UPDIR: ir_q  <= ir_sr;
                ST_CAPDR: begin
                    if (sel_user)
                        user_sr <= user_q;
                    else if (!sel_idcode)
                        bypass_q <= 1'b0;
                end
                ST_SHDR: begin
                    if (sel_user)
                        user_sr <= {TDI_Pad, user_sr[USER_W-1:1]};
                    else if (!sel_idcode)
                        bypass_q <= TDI_Pad;
                end
                ST_UPDDR: begin
                    if (sel_user)
                        user_q <= user_sr;
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, even if tap_state still reads Shift.
    always_comb begin
        TDO_Pad = 1'b0;
        tdo_oe  = 1'b0;
        if (!RST_Pad) begin
            case (st)
                ST_SHIR: begin
                    TDO_Pad = ir_sr[0];
                    tdo_oe  = 1'b1;
                end
                ST_SHDR: begin
                    tdo_oe = 1'b1;
                    if (sel_user)
                        TDO_Pad = user_sr[0];
                    else if (sel_idcode)
                        TDO_Pad = idcode_tdo;
                    else
                        TDO_Pad = bypass_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_dr_chain.sv
// Directed bench for tap_dr_chain: reset, IDCODE scan, IR load, USER write/readback,
// BYPASS, pause/resume and asynchronous reset in the middle of a shift.
module tb_tap_dr_chain;

    typedef enum logic [3:0] {
        EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PAUSEDR = 4'h3,
        SELIR = 4'h4, UPDDR = 4'h5, CAPDR = 4'h6, SELDR   = 4'h7,
        EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PAUSEIR = 4'hB,
        RTI   = 4'hC, UPDIR = 4'hD, CAPIR = 4'hE, TLR     = 4'hF
    } tst_e;

    localparam logic [31:0] ID_VAL   = 32'h1000_0001;
    localparam logic [7:0]  USER_INI = 8'h3C;
`ifdef TAP_DR_IDCODE_EN
    localparam logic [3:0]  IR_RST   = 4'h1;
    localparam logic [31:0] ID_EXP   = ID_VAL;
`else
    localparam logic [3:0]  IR_RST   = 4'hF;
    localparam logic [31:0] ID_EXP   = 32'h0;
`endif

    logic       GCLK_Pad = 1'b0;
    logic       RST_Pad;
    logic [3:0] tap_state;
    logic       TDI_Pad;
    logic       TDO_Pad;
    logic       tdo_oe;
    logic [3:0] ir_q;
    logic [7:0] user_q;

    int total = 0;
    int bad   = 0;

    tap_dr_chain #(
        .IDCODE_VAL (ID_VAL),
        .USER_W     (8),
        .USER_RST   (USER_INI)
    ) dut (
        .GCLK_Pad  (GCLK_Pad),
        .RST_Pad   (RST_Pad),
        .tap_state (tap_state),
        .TDI_Pad   (TDI_Pad),
        .TDO_Pad   (TDO_Pad),
        .tdo_oe    (tdo_oe),
        .ir_q      (ir_q),
        .user_q    (user_q)
    );

    always #5 GCLK_Pad = ~GCLK_Pad;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input logic [3:0] s, input logic t);
        tap_state = s;
        TDI_Pad   = t;
        @(posedge GCLK_Pad);
        #1;
    endtask

    // Shift one DR bit: check TDO before the edge, then take the shift edge.
    task automatic shift_dr(input logic t, input logic exp, input string name, input int idx);
        tap_state = SHDR;
        TDI_Pad   = t;
        #1;
        total++;
        if (TDO_Pad !== exp || tdo_oe !== 1'b1) begin
            bad++;
            $display("FAIL %s bit %0d: tdo=%b oe=%b, expected tdo=%b oe=1", name, idx, TDO_Pad, tdo_oe, exp);
        end
        @(posedge GCLK_Pad);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] ins, input logic [3:0] old_ir);
        logic [3:0] cap;
        cap = 4'b0101;
        step(SELDR, 1'b0);
        step(SELIR, 1'b0);
        step(CAPIR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tap_state = SHIR;
            TDI_Pad   = ins[i];
            #1;
            total++;
            if (TDO_Pad !== cap[i] || tdo_oe !== 1'b1) begin
                bad++;
                $display("FAIL ir_shift bit %0d: tdo=%b oe=%b, expected tdo=%b oe=1", i, TDO_Pad, tdo_oe, cap[i]);
            end
            @(posedge GCLK_Pad);
            #1;
        end
        step(EX1IR, 1'b0);
        total++;
        if (ir_q !== old_ir) begin
            bad++;
            $display("FAIL ir_hold_before_update: ir_q=%h, expected %h", ir_q, old_ir);
        end
        step(UPDIR, 1'b0);
        total++;
        if (ir_q !== ins) begin
            bad++;
            $display("FAIL ir_update: ir_q=%h, expected %h", ir_q, ins);
        end
        step(RTI, 1'b0);
    endtask

    task automatic test_reset;
        RST_Pad   = 1'b1;
        tap_state = TLR;
        TDI_Pad   = 1'b0;
        #2;
        total++;
        if (ir_q !== IR_RST || user_q !== USER_INI || TDO_Pad !== 1'b0 || tdo_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: ir_q=%h user_q=%h tdo=%b oe=%b, expected %h %h 0 0",
                     ir_q, user_q, TDO_Pad, tdo_oe, IR_RST, USER_INI);
        end
        tap_state = SHDR;
        #1;
        total++;
        if (TDO_Pad !== 1'b0 || tdo_oe !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs_quiet: tdo=%b oe=%b, expected 0 0", TDO_Pad, tdo_oe);
        end
        tap_state = TLR;
        @(negedge GCLK_Pad);
        RST_Pad = 1'b0;
    endtask

    task automatic test_idcode;
        step(TLR, 1'b0);
        step(RTI, 1'b0);
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 32; i++)
            shift_dr(1'b0, ID_EXP[i], "idcode", i);
        step(EX1DR, 1'b0);
        step(UPDDR, 1'b0);
        step(RTI, 1'b0);
        total++;
        if (ir_q !== IR_RST || user_q !== USER_INI) begin
            bad++;
            $display("FAIL idcode_side_effects: ir_q=%h user_q=%h, expected %h %h", ir_q, user_q, IR_RST, USER_INI);
        end
    endtask

    task automatic test_ir_load;
        load_ir(4'h2, IR_RST);
    endtask

    task automatic test_user;
        logic [7:0] v;
        v = 8'hA5;
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 8; i++)
            shift_dr(v[i], USER_INI[i], "user_write", i);
        step(EX1DR, 1'b0);
        total++;
        if (user_q !== USER_INI) begin
            bad++;
            $display("FAIL user_hold_before_update: user_q=%h, expected %h", user_q, USER_INI);
        end
        step(UPDDR, 1'b0);
        total++;
        if (user_q !== 8'hA5) begin
            bad++;
            $display("FAIL user_update: user_q=%h, expected a5", user_q);
        end
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 8; i++)
            shift_dr(v[i], v[i], "user_readback", i);
        step(EX1DR, 1'b0);
        step(UPDDR, 1'b0);
        step(RTI, 1'b0);
    endtask

    task automatic test_bypass;
        logic [3:0] tin;
        logic [3:0] tout;
        tin  = 4'b1011;
        tout = 4'b0110;
        load_ir(4'h7, 4'h2);
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 4; i++)
            shift_dr(tin[i], tout[i], "bypass", i);
        step(EX1DR, 1'b0);
        step(UPDDR, 1'b0);
        step(RTI, 1'b0);
        total++;
        if (user_q !== 8'hA5) begin
            bad++;
            $display("FAIL bypass_user_untouched: user_q=%h, expected a5", user_q);
        end
    endtask

    task automatic test_pause;
        logic [7:0] v;
        logic [7:0] old;
        v   = 8'h9E;
        old = 8'hA5;
        load_ir(4'h2, 4'h7);
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 4; i++)
            shift_dr(v[i], old[i], "pause_first", i);
        step(EX1DR, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tap_state = PAUSEDR;
            #1;
            total++;
            if (TDO_Pad !== 1'b0 || tdo_oe !== 1'b0) begin
                bad++;
                $display("FAIL pause_outputs cycle %0d: tdo=%b oe=%b, expected 0 0", i, TDO_Pad, tdo_oe);
            end
            @(posedge GCLK_Pad);
            #1;
        end
        step(EX2DR, 1'b0);
        for (int i = 4; i < 8; i++)
            shift_dr(v[i], old[i], "pause_resume", i);
        step(EX1DR, 1'b0);
        step(UPDDR, 1'b0);
        step(RTI, 1'b0);
        total++;
        if (user_q !== 8'h9E) begin
            bad++;
            $display("FAIL pause_user_update: user_q=%h, expected 9e", user_q);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] cap;
        cap = 8'h9E;
        load_ir(4'h2, 4'h2);
        step(SELDR, 1'b0);
        step(CAPDR, 1'b0);
        for (int i = 0; i < 3; i++)
            shift_dr(1'b0, cap[i], "mid_shift", i);
        tap_state = SHDR;
        TDI_Pad   = 1'b0;
        #1;
        total++;
        if (TDO_Pad !== 1'b1) begin
            bad++;
            $display("FAIL mid_shift_pre_reset: tdo=%b, expected 1", TDO_Pad);
        end
        RST_Pad = 1'b1;
        #1;
        total++;
        if (ir_q !== IR_RST || user_q !== USER_INI || TDO_Pad !== 1'b0 || tdo_oe !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: ir_q=%h user_q=%h tdo=%b oe=%b, expected %h %h 0 0",
                     ir_q, user_q, TDO_Pad, tdo_oe, IR_RST, USER_INI);
        end
        @(posedge GCLK_Pad);
        @(negedge GCLK_Pad);
        RST_Pad   = 1'b0;
        tap_state = RTI;
        load_ir(4'h2, IR_RST);
        total++;
        if (user_q !== USER_INI) begin
            bad++;
            $display("FAIL post_reset_user: user_q=%h, expected %h", user_q, USER_INI);
        end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_ir_load();
        test_user();
        test_bypass();
        test_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
